// File: rtl/k054539_rom_arbiter.sv
// k054539_rom_arbiter: shares one external ROM/RAM port between eight voice channels and the host CPU.
// A grant launches a registered address, and the data byte is captured ACCESS_CYCLES edges later.
module k054539_rom_arbiter #(
  parameter int ACCESS_CYCLES = 3
) (
  input  logic        CLK,
  input  logic        NRES,
  input  logic [7:0]  CH_REQ,
  output logic [2:0]  CH_SEL,
  input  logic [23:0] CH_ADDR,
  output logic [7:0]  CH_ACK,
  output logic [7:0]  CH_DATA,
  input  logic        HOST_REQ,
  input  logic        HOST_WR,
  input  logic [23:0] HOST_ADDR,
  input  logic [7:0]  HOST_WDATA,
  output logic        HOST_ACK,
  output logic [7:0]  HOST_RDATA,
  output logic        PIN_WAIT,
  output logic [23:0] PIN_RA,
  input  logic [7:0]  PIN_RD_IN,
  output logic [7:0]  PIN_RD_OUT,
  output logic        PIN_RD_OE,
  output logic        NRAMWE
);
  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  ptr_q, ptr_d, sel_q, sel_d, cand;
  logic        prev_ch_q, prev_ch_d, host_q, host_d, wr_q, wr_d;
  logic [23:0] ra_q, ra_d;
  logic [7:0]  rdout_q, rdout_d, ch_ack_q, ch_ack_d, ch_data_q, ch_data_d, host_rdata_q, host_rdata_d;
  logic        oe_q, oe_d, we_n_q, we_n_d, host_ack_q, host_ack_d, host_win;

  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ptr_q        <= 3'd7;
      sel_q        <= '0;
      prev_ch_q    <= 1'b1;
      host_q       <= 1'b0;
      wr_q         <= 1'b0;
      ra_q         <= '0;
      rdout_q      <= '0;
      oe_q         <= 1'b0;
      we_n_q       <= 1'b1;
      ch_ack_q     <= '0;
      host_ack_q   <= 1'b0;
      ch_data_q    <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      sel_q        <= sel_d;
      prev_ch_q    <= prev_ch_d;
      host_q       <= host_d;
      wr_q         <= wr_d;
      ra_q         <= ra_d;
      rdout_q      <= rdout_d;
      oe_q         <= oe_d;
      we_n_q       <= we_n_d;
      ch_ack_q     <= ch_ack_d;
      host_ack_q   <= host_ack_d;
      ch_data_q    <= ch_data_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  always_comb begin
    // Descending scan so the nearest requester after the last grant wins
    cand = ptr_q + 3'd1;
    for (int i = 8; i >= 1; i--)
      if (CH_REQ[ptr_q + 3'(i)]) cand = ptr_q + 3'(i);
    host_win     = HOST_REQ && (prev_ch_q || CH_REQ == '0);
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    sel_d        = sel_q;
    prev_ch_d    = prev_ch_q;
    host_d       = host_q;
    wr_d         = wr_q;
    ra_d         = ra_q;
    rdout_d      = rdout_q;
    oe_d         = oe_q;
    we_n_d       = we_n_q;
    ch_ack_d     = '0;
    host_ack_d   = 1'b0;
    ch_data_d    = ch_data_q;
    host_rdata_d = host_rdata_q;
    if (state_q == IDLE) begin
      if (host_win || CH_REQ != '0) begin
        state_d   = ACCESS;
        cnt_d     = 4'(ACCESS_CYCLES - 1);
        host_d    = host_win;
        wr_d      = host_win && HOST_WR;
        prev_ch_d = !host_win;
        ra_d      = host_win ? HOST_ADDR : CH_ADDR;
        sel_d     = host_win ? sel_q : cand;
        ptr_d     = host_win ? ptr_q : cand;
        rdout_d   = (host_win && HOST_WR) ? HOST_WDATA : rdout_q;
        oe_d      = host_win && HOST_WR;
        we_n_d    = !(host_win && HOST_WR);
      end
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - 4'd1;
      // Strobe releases one cycle early so data is still driven at the rising write edge
      we_n_d = !(wr_q && cnt_q != 4'd1);
    end else begin
      state_d      = IDLE;
      oe_d         = 1'b0;
      we_n_d       = 1'b1;
      host_ack_d   = host_q;
      ch_ack_d     = host_q ? 8'd0 : 8'd1 << sel_q;
      host_rdata_d = (host_q && !wr_q) ? PIN_RD_IN : host_rdata_q;
      ch_data_d    = host_q ? ch_data_q : PIN_RD_IN;
    end
  end

  assign CH_SEL     = (state_q == IDLE) ? cand : sel_q;
  assign CH_ACK     = ch_ack_q;
  assign CH_DATA    = ch_data_q;
  assign HOST_ACK   = host_ack_q;
  assign HOST_RDATA = host_rdata_q;
  assign PIN_WAIT   = HOST_REQ && !host_ack_q;
  assign PIN_RA     = ra_q;
  assign PIN_RD_OUT = rdout_q;
  assign PIN_RD_OE  = oe_q;
  assign NRAMWE     = we_n_q;
endmodule
